// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-period helper
// used by both uart_rx and uart_tx.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic int clks_per_bit(input int clock, input int baud);
        return clock / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous inputs (rx line, e_intr).
// RST_VAL sets both flops so the output starts at the line's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs at the same edge, forming a true two-stage chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a read-clear holding register, sticky framing-error
// and overrun flags, and a peripheral-bus read port (cs & re).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DW        = 8,
    parameter int CLOCK     = 100000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          rx_i,
    input  logic          cs,
    input  logic          re,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          frame_err_o,
    output logic          overrun_o,
    output logic          busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = (DW > 1) ? $clog2(DW) : 1;

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end

    logic rx_s;
    logic rd;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [DW-1:0]    data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;
    logic             busy_q;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx_i),
        .q_o   (rx_s)
    );

    assign rd = cs & re;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = rd ? 1'b0 : valid_q;
        ferr_d  = rd ? 1'b0 : ferr_q;
        ovr_d   = rd ? 1'b0 : ovr_q;

        unique case (state_q)
            UART_IDLE: begin
                if (!rx_s) begin
                    state_d = UART_START;
                    cnt_d   = '0;
                end
            end
            UART_START: begin
                if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? UART_IDLE : UART_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_W'(DW - 1)) begin
                        state_d = UART_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_STOP: begin
                if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    // Re-arm at the stop-bit centre so a following start edge is caught.
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !rd) begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != UART_IDLE);
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frame, glitch,
// framing error, overrun/back-to-back, and reset in the middle of a frame.
module tb_uart_rx;

    localparam int BIT = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       rx_i  = 1'b1;
    logic       cs    = 1'b0;
    logic       re    = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    uart_rx #(.DW(8), .CLOCK(16), .BAUD_RATE(1)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .cs          (cs),
        .re          (re),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Drives one 8N1 frame, 16 cycles per bit. Cycle index c (0..159) of the
    // frame can carry a read strobe (read_at) or a reset pulse (rst_at).
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int read_at, input int rst_at);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < BIT; c++) begin
                rx_i  = bits[n];
                cs    = (n * BIT + c == read_at);
                re    = (n * BIT + c == read_at);
                rst_i = (n * BIT + c == rst_at);
                @(posedge clk_i);
                #1;
            end
        end
        rx_i  = 1'b1;
        cs    = 1'b0;
        re    = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        idle(2);
    endtask

    task automatic test_good_frame;
        int   n_seen;
        logic found;
        logic busy_at;
        logic [7:0] data_at;
        logic ferr_at;
        logic ovr_at;
        n_seen = 0;
        found  = 1'b0;
        busy_at = 1'b1;
        data_at = 8'h00;
        ferr_at = 1'b1;
        ovr_at  = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, -1, -1);
            begin
                for (int i = 1; i <= 300; i++) begin
                    @(negedge clk_i);
                    if (valid_o === 1'b1) begin
                        found   = 1'b1;
                        n_seen  = i;
                        busy_at = busy_o;
                        data_at = data_o;
                        ferr_at = frame_err_o;
                        ovr_at  = overrun_o;
                        break;
                    end
                end
            end
        join
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL good_valid_timeout: valid_o never rose within 300 cycles"); end
        checks++; if (n_seen < 150 || n_seen > 162) begin errors++; $display("FAIL good_latency: got %0d cycles want 150..162", n_seen); end
        checks++; if (data_at !== 8'hA5) begin errors++; $display("FAIL good_data: got %h want a5", data_at); end
        checks++; if (busy_at !== 1'b0) begin errors++; $display("FAIL good_busy_fall: got %b want 0", busy_at); end
        checks++; if (ferr_at !== 1'b0) begin errors++; $display("FAIL good_ferr: got %b want 0", ferr_at); end
        checks++; if (ovr_at !== 1'b0) begin errors++; $display("FAIL good_ovr: got %b want 0", ovr_at); end

        cs = 1'b1; re = 1'b1;
        @(negedge clk_i);
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL read_cycle_data: got %h want a5", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL read_cycle_valid: got %b want 1", valid_o); end
        @(posedge clk_i); #1;
        cs = 1'b0; re = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL read_clear_valid: got %b want 0", valid_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL read_keep_data: got %h want a5", data_o); end
        idle(4);
    endtask

    task automatic test_glitch;
        rx_i = 1'b0;
        idle(3);
        rx_i = 1'b1;
        idle(1);
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", busy_o); end
        idle(9);
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %b want 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b want 0", frame_err_o); end
        idle(4);
    endtask

    task automatic test_frame_error;
        send_frame(8'h3C, 1'b0, -1, -1);
        idle(30);
        @(negedge clk_i);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", valid_o); end
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h want a5", data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", busy_o); end

        re = 1'b1;
        idle(1);
        re = 1'b0;
        cs = 1'b1;
        idle(1);
        cs = 1'b0;
        @(negedge clk_i);
        checks++; if (frame_err_o !== 1'b1) begin errors++; $display("FAIL ferr_partial_read: got %b want 1", frame_err_o); end

        cs = 1'b1; re = 1'b1;
        idle(1);
        cs = 1'b0; re = 1'b0;
        @(negedge clk_i);
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL ferr_read_clear: got %b want 0", frame_err_o); end
        idle(4);
    endtask

    task automatic test_back_to_back;
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(4);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h want 22", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", valid_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun_o); end

        // Read lands on the edge where the 0x33 stop bit is sampled (cycle 154 -> edge 155).
        send_frame(8'h33, 1'b1, 154, -1);
        idle(2);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h33) begin errors++; $display("FAIL rdwin_data: got %h want 33", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rdwin_valid: got %b want 1", valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rdwin_overrun: got %b want 0", overrun_o); end
        idle(4);
    endtask

    task automatic test_reset_mid_frame;
        // Cycle 84 lies inside data bit 4 (bit 4 is sampled at edge 91).
        send_frame(8'hFF, 1'b1, -1, 84);
        idle(4);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL midrst_ovr: got %b want 0", overrun_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy_o); end

        send_frame(8'h5A, 1'b1, -1, -1);
        idle(4);
        @(negedge clk_i);
        checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL after_rst_data: got %h want 5a", data_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL after_rst_valid: got %b want 1", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL after_rst_ferr: got %b want 0", frame_err_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL after_rst_ovr: got %b want 0", overrun_o); end
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
